reg32_serializer: RTL and testbench
===================================

# reg32_serializer

Read-side companion to the 32-bit load-enable register: captures a parallel word on a load handshake and shifts it out one bit per accepted cycle over a valid/ready serial stream. It sits between the register datapath and any bit-serial consumer (test port, link transmitter) and reports completion with a one-cycle done pulse.

## Interface
- WIDTH, 32, word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load  in  1  request to capture din; accepted only when ready=1
- din  in  WIDTH  parallel word to transmit
- ready  out  1  1 = idle, load will be accepted this cycle
- sout  out  1  current serial bit
- svalid  out  1  sout holds a valid bit
- sready  in  1  consumer accepts sout this cycle
- last  out  1  current sout is the final bit of the word
- done  out  1  one-cycle pulse after the final bit is accepted

## Operation
- States: IDLE, SHIFT.
- IDLE: ready=1, svalid=0. If load=1, capture din into the shift register, clear bit counter, go to SHIFT.
- SHIFT: ready=0, svalid=1, sout = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0).
- Transfer occurs on an edge with svalid=1 and sready=1. On transfer, shift by one (vacated bit filled with 0) and increment counter.
- Counter width $clog2(WIDTH); last=1 when counter == WIDTH-1 in SHIFT.
- Transfer while last=1: go to IDLE, assert done for the following cycle.
- sready=0 in SHIFT: hold sout, counter and state (stall, any length).
- load while not IDLE: ignored, no effect on data in flight. din is sampled only on the accepting edge.
- rst=1: state IDLE, shreg=0, counter=0, done=0. Overrides load and any transfer on the same edge. Reset mid-word aborts without done.

## Timing
- Reset values: ready=1, sout=0, svalid=0, last=0, done=0.
- All outputs registered or decoded from registered state only; no combinational path from sready, load or din to any output.
- Load accepted at edge k → svalid=1 with the first bit from cycle k+1.
- With sready held high: bit i is presented in cycle k+1+i. last is high in cycle k+WIDTH. IDLE, ready=1 and done=1 in cycle k+WIDTH+1.
- Minimum word period WIDTH+1 cycles (one idle bubble). A load in the done cycle is accepted.
- Each sready=0 cycle in SHIFT adds exactly one cycle to the sequence.

## Structure
- Package reg32_ser_pkg: state enum (IDLE, SHIFT), default WIDTH constant.
- Sub-module shreg: WIDTH-bit shift register with synchronous reset, parallel load, shift-enable and a direction parameter. The top module holds the FSM, counter and done flop.

## Test plan
- Reset: rst high for 2 cycles with load=1, din=32'h00000003 → ready=1, svalid=0, sout=0, done=0. No capture occurs.
- Basic MSB-first: load 32'h00000005, sready=1 → svalid high 32 cycles, sout=0 for bits 31..3, then 1,0,1. last only on the 32nd bit. done pulses at cycle 33 after load.
- Stall: load 32'h80000001, drop sready for 3 cycles at bits 0 and 31 → sout is held during each stall, total sequence is 35 valid cycles, bit order is unchanged.
- Load while busy: mid-word, pulse load with din=32'hFFFFFFFF → ignored, original word completes intact, ready stays 0 until done.
- Back-to-back: load 32'h00000003, then load 32'h00000005 in the done cycle → second word starts the next cycle. Stream is 1,1 then 1,0,1 at the respective word tails.
- Reset mid-word: assert rst at bit 10 → next cycle IDLE, svalid=0, no done pulse. A subsequent load of 32'h00000005 transmits correctly.

Source files
------------

// File: rtl/reg32_ser_pkg.sv
// Shared types and defaults for the bit-serial read-out of the 32-bit register.
package reg32_ser_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } ser_state_e;

endpackage

// File: rtl/reg32_serializer_shreg.sv
// Parallel-load shift register. The serial tap sits at the end that leaves first,
// and the vacated end fills with zeros.
module reg32_serializer_shreg #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             shift_i,
  output logic             sout_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // Next-state: load wins over shift; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = din_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end else begin
        q_d = {1'b0, q_q[WIDTH-1:1]};
      end
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign sout_o = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: rtl/reg32_serializer.sv
// Captures a parallel word on a load handshake and streams it out one bit per
// accepted cycle over valid/ready, pulsing done once the final bit is taken.
module reg32_serializer
  import reg32_ser_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             ready_o,
  output logic             sout_o,
  output logic             svalid_o,
  input  logic             sready_i,
  output logic             last_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  ser_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            load_en, shift_en;
  logic            shreg_bit;

  reg32_serializer_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_en),
    .din_i   (din_i),
    .shift_i (shift_en),
    .sout_o  (shreg_bit)
  );

  // Next-state: accept a load only when idle; advance only on a transfer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          load_en = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (sready_i) begin
          shift_en = 1'b1;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State, bit counter and done flop; reset aborts any word without done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode registered state only; sout is forced low while idle.
  always_comb begin
    ready_o  = (state_q == StIdle);
    svalid_o = (state_q == StShift);
    last_o   = svalid_o && (cnt_q == LastCnt);
    sout_o   = svalid_o & shreg_bit;
    done_o   = done_q;
  end

endmodule

// File: tb/tb_reg32_serializer.sv
// Directed bench for reg32_serializer (WIDTH=32, MSB first).
module tb_reg32_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] din;
  logic        ready;
  logic        sout;
  logic        svalid;
  logic        sready;
  logic        last;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  reg32_serializer #(
    .WIDTH     (32),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load),
    .din_i    (din),
    .ready_o  (ready),
    .sout_o   (sout),
    .svalid_o (svalid),
    .sready_i (sready),
    .last_o   (last),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first SHIFT cycle. Stalls stall_a cycles at bit 0 and stall_b at
  // bit 31; optionally pulses load with all-ones mid-word. Returns in the cycle after
  // the final transfer.
  task automatic recv_word(input logic [31:0] word, input int stall_a, input int stall_b,
                           input bit busy_load, output int valid_cycles);
    int idx    = 0;
    int stalls = 0;
    int budget = 200;
    logic [31:0] w = word;
    valid_cycles = 0;
    load = 1'b0;
    while (idx < 32 && budget > 0) begin
      budget--;
      check("svalid", {31'b0, svalid}, 32'd1);
      check("ready_busy", {31'b0, ready}, 32'd0);
      check("sout", {31'b0, sout}, {31'b0, w[31-idx]});
      check("last", {31'b0, last}, {31'b0, (idx == 31)});
      check("done_busy", {31'b0, done}, 32'd0);
      if (svalid) valid_cycles++;
      if ((idx == 0 && stalls < stall_a) || (idx == 31 && stalls < stall_b)) begin
        sready = 1'b0;
        stalls++;
      end else begin
        sready = 1'b1;
      end
      if (busy_load && idx == 10) begin
        load = 1'b1;
        din  = 32'hFFFF_FFFF;
      end else begin
        load = 1'b0;
      end
      tick();
      if (sready) begin
        idx++;
        stalls = 0;
      end
    end
    if (budget == 0) check("recv_timeout", 32'd1, 32'd0);
    sready = 1'b0;
    load   = 1'b0;
    check("done_pulse", {31'b0, done}, 32'd1);
    check("ready_done", {31'b0, ready}, 32'd1);
    check("svalid_done", {31'b0, svalid}, 32'd0);
    check("last_done", {31'b0, last}, 32'd0);
  endtask

  task automatic start_word(input logic [31:0] word);
    load = 1'b1;
    din  = word;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int vc;
    logic [31:0] w5;

    // Reset with a pending load: nothing may be captured.
    rst    = 1'b1;
    load   = 1'b1;
    din    = 32'h0000_0003;
    sready = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_svalid", {31'b0, svalid}, 32'd0);
    check("rst_sout", {31'b0, sout}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_last", {31'b0, last}, 32'd0);
    rst  = 1'b0;
    load = 1'b0;
    tick();
    check("post_rst_svalid", {31'b0, svalid}, 32'd0);
    check("post_rst_ready", {31'b0, ready}, 32'd1);

    // Basic MSB-first.
    start_word(32'h0000_0005);
    recv_word(32'h0000_0005, 0, 0, 1'b0, vc);
    check("basic_valid_cycles", vc, 32'd32);
    tick();
    check("done_one_cycle", {31'b0, done}, 32'd0);

    // Stalls at bit 0 (2 cycles) and bit 31 (1 cycle).
    start_word(32'h8000_0001);
    recv_word(32'h8000_0001, 2, 1, 1'b0, vc);
    check("stall_valid_cycles", vc, 32'd35);
    tick();

    // Load while busy must be ignored.
    start_word(32'h0000_0005);
    recv_word(32'h0000_0005, 0, 0, 1'b1, vc);
    check("busy_valid_cycles", vc, 32'd32);
    tick();

    // Back-to-back: second load lands in the done cycle.
    start_word(32'h0000_0003);
    recv_word(32'h0000_0003, 0, 0, 1'b0, vc);
    start_word(32'h0000_0005);
    check("b2b_svalid", {31'b0, svalid}, 32'd1);
    check("b2b_done_clear", {31'b0, done}, 32'd0);
    recv_word(32'h0000_0005, 0, 0, 1'b0, vc);
    check("b2b_valid_cycles", vc, 32'd32);
    tick();

    // Reset mid-word at bit 10: abort without done.
    start_word(32'h0000_0005);
    w5     = 32'h0000_0005;
    sready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("pre_abort_sout", {31'b0, sout}, {31'b0, w5[31-i]});
      tick();
    end
    sready = 1'b1;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    sready = 1'b0;
    check("abort_svalid", {31'b0, svalid}, 32'd0);
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_sout", {31'b0, sout}, 32'd0);
    tick();
    check("abort_no_done", {31'b0, done}, 32'd0);
    start_word(32'h0000_0005);
    recv_word(32'h0000_0005, 0, 0, 1'b0, vc);
    check("after_abort_cycles", vc, 32'd32);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
